ras: RTL and testbench

//  Return address stack for the fetch-stage branch predictor. Fetch pushes a link target on each call
//  and pops a predicted target on each return. The branch resolution unit restores a checkpoint on a

---
 rtl/ras_if.sv | 33 +++
 rtl/ras.sv | 78 +++++++
 tb/tb_ras.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ras_if.sv
// Fetch <-> return-address-stack signal bundle: push/pop/restore requests and checkpoint outputs.
// Latency: none, wires only.
// Backpressure: none, the stack accepts a request every cycle.
interface ras_if #(
    parameter int RAS_DEPTH        = 8,
    parameter int RAS_TARGET_WIDTH = 14,
    parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
);
    logic                        link_valid;
    logic [RAS_TARGET_WIDTH-1:0] link_target;
    logic                        ret_valid;
    logic [RAS_TARGET_WIDTH-1:0] ret_target;
    logic                        ret_target_valid;
    logic [LOG_RAS_DEPTH-1:0]    ras_index;
    logic [LOG_RAS_DEPTH:0]      ras_count;
    logic                        restore_valid;
    logic [LOG_RAS_DEPTH-1:0]    restore_ras_index;
    logic [LOG_RAS_DEPTH:0]      restore_ras_count;

    // Fetch / branch-resolution side
    modport master (
        output link_valid, link_target, ret_valid,
        output restore_valid, restore_ras_index, restore_ras_count,
        input  ret_target, ret_target_valid, ras_index, ras_count
    );

    // Stack side
    modport slave (
        input  link_valid, link_target, ret_valid,
        input  restore_valid, restore_ras_index, restore_ras_count,
        output ret_target, ret_target_valid, ras_index, ras_count
    );
endinterface

// File: rtl/ras.sv
// Circular return address stack with checkpoint restore for the fetch-stage predictor.
// Latency: push/pop/restore visible on outputs 1 cycle after the request edge; outputs are pure state.
// Backpressure: none; overflow silently overwrites the oldest entry, pop on empty is ignored.
module ras #(
    parameter int RAS_DEPTH        = 8,
    parameter int RAS_TARGET_WIDTH = 14,
    parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
    input  logic   clk,
    input  logic   rst,
    ras_if.slave   bus
);
    localparam logic [LOG_RAS_DEPTH:0]   FULL_COUNT = (LOG_RAS_DEPTH + 1)'(RAS_DEPTH);
    localparam logic [LOG_RAS_DEPTH-1:0] PTR_ONE    = LOG_RAS_DEPTH'(1);
    localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE    = (LOG_RAS_DEPTH + 1)'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack [RAS_DEPTH];
    logic [LOG_RAS_DEPTH-1:0]    ptr;
    logic [LOG_RAS_DEPTH:0]      count;

    logic                        replace_en;
    logic                        push_en;
    logic                        pop_en;
    logic                        wr_en;
    logic [LOG_RAS_DEPTH-1:0]    wr_addr;
    logic [LOG_RAS_DEPTH-1:0]    ptr_inc;
    logic [LOG_RAS_DEPTH-1:0]    ptr_dec;

    assign ptr_inc = ptr + PTR_ONE;   // wraps modulo depth (power of two)
    assign ptr_dec = ptr - PTR_ONE;

    // Decode the request with restore taking priority over push/pop (fetch is being redirected)
    always_comb begin
        replace_en = 1'b0;
        push_en    = 1'b0;
        pop_en     = 1'b0;
        if (!bus.restore_valid) begin
            replace_en = bus.link_valid && bus.ret_valid;
            push_en    = bus.link_valid && !bus.ret_valid;
            pop_en     = bus.ret_valid && !bus.link_valid && (count != '0);
        end
        wr_en   = replace_en || push_en;
        wr_addr = push_en ? ptr_inc : ptr;
    end

    // Top pointer and occupancy; count saturates at depth and never goes below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (bus.restore_valid) begin
            ptr   <= bus.restore_ras_index;
            count <= bus.restore_ras_count;
        end else if (replace_en) begin
            if (count == '0) count <= CNT_ONE;
        end else if (push_en) begin
            ptr <= ptr_inc;
            if (count != FULL_COUNT) count <= count + CNT_ONE;
        end else if (pop_en) begin
            ptr   <= ptr_dec;
            count <= count - CNT_ONE;
        end
    end

    // Entry storage; restore leaves entries intact so the checkpointed top is still there
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
        end else if (wr_en) begin
            stack[wr_addr] <= bus.link_target;
        end
    end

    assign bus.ret_target       = stack[ptr];
    assign bus.ret_target_valid = (count != '0);
    assign bus.ras_index        = ptr;
    assign bus.ras_count        = count;
endmodule

// File: tb/tb_ras.sv
// Directed self-checking bench for the return address stack.
// Latency: checks taken 1 time unit after the update edge.
// Backpressure: none exercised; the stack never stalls.
module tb_ras;
    localparam int DEPTH = 8;
    localparam int TW    = 14;
    localparam int LOG   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ras_if #(.RAS_DEPTH(DEPTH), .RAS_TARGET_WIDTH(TW), .LOG_RAS_DEPTH(LOG)) bus ();

    ras #(.RAS_DEPTH(DEPTH), .RAS_TARGET_WIDTH(TW), .LOG_RAS_DEPTH(LOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Restoring an occupancy above the depth is an illegal checkpoint
    always @(posedge clk) begin
        if (!rst && bus.restore_valid)
            assert (bus.restore_ras_count <= 4'(DEPTH))
                else $error("illegal restore_ras_count %0d", bus.restore_ras_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.link_valid        = 1'b0;
        bus.link_target       = '0;
        bus.ret_valid         = 1'b0;
        bus.restore_valid     = 1'b0;
        bus.restore_ras_index = '0;
        bus.restore_ras_count = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [TW-1:0] t);
        bus.link_valid  = 1'b1;
        bus.link_target = t;
        tick();
        idle();
    endtask

    task automatic pop();
        bus.ret_valid = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        bus.link_valid  = 1'b1;
        bus.link_target = 14'h155;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (bus.ras_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.ras_count); end
        checks++;
        if (bus.ras_index !== 3'd0) begin errors++; $display("FAIL reset_index got %0d want 0", bus.ras_index); end
        checks++;
        if (bus.ret_target_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.ret_target_valid); end
        checks++;
        if (bus.ret_target !== 14'h0) begin errors++; $display("FAIL reset_target got %h want 0", bus.ret_target); end
    endtask

    task automatic test_push_pop();
        logic [TW-1:0] exp_t [3];
        exp_t[0] = 14'h300; exp_t[1] = 14'h200; exp_t[2] = 14'h100;
        do_reset();
        push(14'h100); push(14'h200); push(14'h300);
        checks++;
        if (bus.ras_count !== 4'd3) begin errors++; $display("FAIL pp_count got %0d want 3", bus.ras_count); end
        checks++;
        if (bus.ras_index !== 3'd3) begin errors++; $display("FAIL pp_index got %0d want 3", bus.ras_index); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.ret_target !== exp_t[i] || bus.ret_target_valid !== 1'b1) begin
                errors++; $display("FAIL pp_pop%0d got %h/%b want %h/1", i, bus.ret_target, bus.ret_target_valid, exp_t[i]);
            end
            pop();
        end
        checks++;
        if (bus.ret_target_valid !== 1'b0 || bus.ras_count !== 4'd0) begin
            errors++; $display("FAIL pp_empty got valid %b count %0d want 0 0", bus.ret_target_valid, bus.ras_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) push(14'(i));
        checks++;
        if (bus.ras_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", bus.ras_count); end
        checks++;
        if (bus.ras_index !== 3'd1) begin errors++; $display("FAIL ovf_index got %0d want 1", bus.ras_index); end
        checks++;
        if (bus.ret_target !== 14'h009) begin errors++; $display("FAIL ovf_top got %h want 009", bus.ret_target); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.ret_target !== 14'(9 - i)) begin
                errors++; $display("FAIL ovf_pop%0d got %h want %h", i, bus.ret_target, 14'(9 - i));
            end
            pop();
        end
        checks++;
        if (bus.ret_target_valid !== 1'b0 || bus.ras_count !== 4'd0 || bus.ras_index !== 3'd1) begin
            errors++; $display("FAIL ovf_drained got valid %b count %0d index %0d want 0 0 1",
                               bus.ret_target_valid, bus.ras_count, bus.ras_index);
        end
        // Pointer wrap 0-1 -> 7: restore a full stack at index 0, then pop
        bus.restore_valid     = 1'b1;
        bus.restore_ras_index = 3'd0;
        bus.restore_ras_count = 4'd8;
        tick();
        idle();
        checks++;
        if (bus.ret_target !== 14'h008 || bus.ras_count !== 4'd8) begin
            errors++; $display("FAIL wrap_restore got %h count %0d want 008 8", bus.ret_target, bus.ras_count);
        end
        pop();
        checks++;
        if (bus.ras_index !== 3'd7 || bus.ras_count !== 4'd7 || bus.ret_target !== 14'h007) begin
            errors++; $display("FAIL wrap_pop got index %0d count %0d top %h want 7 7 007",
                               bus.ras_index, bus.ras_count, bus.ret_target);
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pop();
            checks++;
            if (bus.ras_index !== 3'd0 || bus.ras_count !== 4'd0 || bus.ret_target_valid !== 1'b0) begin
                errors++; $display("FAIL empty_pop%0d got index %0d count %0d valid %b want 0 0 0",
                                   i, bus.ras_index, bus.ras_count, bus.ret_target_valid);
            end
        end
    endtask

    task automatic test_replace();
        do_reset();
        push(14'h0AA);
        bus.link_valid  = 1'b1;
        bus.ret_valid   = 1'b1;
        bus.link_target = 14'h0BB;
        tick();
        idle();
        checks++;
        if (bus.ras_count !== 4'd1 || bus.ret_target !== 14'h0BB || bus.ras_index !== 3'd1) begin
            errors++; $display("FAIL replace got count %0d top %h index %0d want 1 0bb 1",
                               bus.ras_count, bus.ret_target, bus.ras_index);
        end
        do_reset();
        bus.link_valid  = 1'b1;
        bus.ret_valid   = 1'b1;
        bus.link_target = 14'h0BB;
        tick();
        idle();
        checks++;
        if (bus.ras_count !== 4'd1 || bus.ret_target !== 14'h0BB || bus.ras_index !== 3'd0
            || bus.ret_target_valid !== 1'b1) begin
            errors++; $display("FAIL replace_empty got count %0d top %h index %0d want 1 0bb 0",
                               bus.ras_count, bus.ret_target, bus.ras_index);
        end
    endtask

    task automatic test_restore();
        do_reset();
        push(14'h010); push(14'h020);
        checks++;
        if (bus.ras_index !== 3'd2 || bus.ras_count !== 4'd2) begin
            errors++; $display("FAIL ckpt got index %0d count %0d want 2 2", bus.ras_index, bus.ras_count);
        end
        push(14'h030);
        pop(); pop(); pop();
        bus.restore_valid     = 1'b1;
        bus.restore_ras_index = 3'd2;
        bus.restore_ras_count = 4'd2;
        bus.link_valid        = 1'b1;
        bus.link_target       = 14'h3FF;
        tick();
        idle();
        checks++;
        if (bus.ras_index !== 3'd2 || bus.ras_count !== 4'd2 || bus.ret_target !== 14'h020) begin
            errors++; $display("FAIL restore got index %0d count %0d top %h want 2 2 020",
                               bus.ras_index, bus.ras_count, bus.ret_target);
        end
        pop();
        checks++;
        if (bus.ret_target !== 14'h010 || bus.ras_count !== 4'd1) begin
            errors++; $display("FAIL restore_pop got %h count %0d want 010 1", bus.ret_target, bus.ras_count);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_push_pop();
        test_overflow();
        test_empty_pop();
        test_replace();
        test_restore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
